// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel button conditioner with a synchroniser, a consecutive-cycle filter and rise/fall strobes.
// Define DEBOUNCE_HOLD_EN to add a per-channel long-press pulse on o_hold; otherwise o_hold is tied low.
module multi_debouncer #(
   parameter int N_CH        = 4,
   parameter int DELAY       = 1_000_000,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 200_000_000
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic [N_CH-1:0] i_btn_in,
   output logic [N_CH-1:0] o_btn_db,
   output logic [N_CH-1:0] o_rise,
   output logic [N_CH-1:0] o_fall,
   output logic [N_CH-1:0] o_hold
);

   localparam int               CNT_W    = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [N_CH-1:0] r_sync [SYNC_STAGES];
   logic [N_CH-1:0] w_s;

   // NOTE: the synchroniser chain is plain state, so every stage is reset and
   // shifted with non-blocking assignments; blocking ones would collapse the chain.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      end else begin
         r_sync[0] <= i_btn_in;
         for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   genvar c;
   generate
      for (c = 0; c < N_CH; c++) begin : g_ch
         logic [CNT_W-1:0] r_cnt;
         logic             r_db;
         logic             r_rise;
         logic             r_fall;
         logic             w_diff;
         logic             w_accept;

         assign w_diff   = w_s[c] ^ r_db;
         assign w_accept = w_diff && (r_cnt == CNT_LAST);

         // Any cycle where the synchronised level agrees with r_db restarts the count.
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_cnt  <= '0;
               r_db   <= 1'b0;
               r_rise <= 1'b0;
               r_fall <= 1'b0;
            end else begin
               r_rise <= w_accept &&  w_s[c];
               r_fall <= w_accept && !w_s[c];
               if (!w_diff || w_accept) r_cnt <= '0;
               else                     r_cnt <= r_cnt + CNT_ONE;
               if (w_accept) r_db <= w_s[c];
            end
         end

         assign o_btn_db[c] = r_db;
         assign o_rise[c]   = r_rise;
         assign o_fall[c]   = r_fall;

`ifdef DEBOUNCE_HOLD_EN
         localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
         localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
         localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(HOLD_CYCLES - 1);
         localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

         logic [HOLD_W-1:0] r_hold_cnt;
         logic              r_hold;

         // Saturation at HOLD_LAST guarantees a single pulse until the level drops.
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_hold_cnt <= '0;
               r_hold     <= 1'b0;
            end else begin
               r_hold <= 1'b0;
               if (!r_db) begin
                  r_hold_cnt <= '0;
               end else if (r_hold_cnt != HOLD_LAST) begin
                  r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                  r_hold     <= (r_hold_cnt == HOLD_PRE);
               end
            end
         end

         assign o_hold[c] = r_hold;
`else
         assign o_hold[c] = 1'b0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed bench for multi_debouncer with DELAY=16, SYNC_STAGES=2, N_CH=4, HOLD_CYCLES=40.
// Long-press expectations follow DEBOUNCE_HOLD_EN; without it o_hold must stay 0.
module tb_multi_debouncer;

   localparam int N_CH        = 4;
   localparam int DELAY       = 16;
   localparam int SYNC_STAGES = 2;
   localparam int HOLD_CYCLES = 40;
   localparam int LAT         = SYNC_STAGES + DELAY;
`ifdef DEBOUNCE_HOLD_EN
   localparam logic HOLD_ON = 1'b1;
`else
   localparam logic HOLD_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rstn;
   logic [N_CH-1:0] btn;
   logic [N_CH-1:0] db;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic [N_CH-1:0] hold;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multi_debouncer #(
      .N_CH        (N_CH),
      .DELAY       (DELAY),
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_btn_in (btn),
      .o_btn_db (db),
      .o_rise   (rise),
      .o_fall   (fall),
      .o_hold   (hold)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [N_CH-1:0] e_db, input logic [N_CH-1:0] e_rise,
                            input logic [N_CH-1:0] e_fall, input logic [N_CH-1:0] e_hold);
      check({tag, "/db"},   db,   e_db);
      check({tag, "/rise"}, rise, e_rise);
      check({tag, "/fall"}, fall, e_fall);
      check({tag, "/hold"}, hold, e_hold);
   endtask

   // Drive a clean step and verify nothing moves before edge LAT, the strobe on LAT, and its removal after.
   task automatic step_edge(input string tag, input logic [N_CH-1:0] nb, input logic [N_CH-1:0] db_before,
                            input logic [N_CH-1:0] db_after, input logic [N_CH-1:0] e_rise,
                            input logic [N_CH-1:0] e_fall);
      btn = nb;
      tick(LAT - 1);
      check_all({tag, "_pre"}, db_before, '0, '0, '0);
      tick(1);
      check_all({tag, "_edge"}, db_after, e_rise, e_fall, '0);
      tick(1);
      check_all({tag, "_post"}, db_after, '0, '0, '0);
   endtask

   initial begin
      logic [N_CH-1:0] seen;
      logic            lvl;
      int              w;

      // Reset held with all inputs high.
      rstn = 1'b0;
      btn  = 4'hF;
      tick(50);
      check_all("reset_hold", '0, '0, '0, '0);
      rstn = 1'b1;
      tick(LAT - 1);
      check_all("reset_rel_pre", '0, '0, '0, '0);
      tick(1);
      check_all("reset_rel_edge", 4'hF, 4'hF, '0, '0);
      tick(1);
      check_all("reset_rel_post", 4'hF, '0, '0, '0);

      // All low, then a clean ch0 press and release.
      step_edge("all_fall", 4'h0, 4'hF, 4'h0, 4'h0, 4'hF);
      step_edge("ch0_rise", 4'h1, 4'h0, 4'h1, 4'h1, 4'h0);
      step_edge("ch0_fall", 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);

      // Random glitch train on ch1, every excursion shorter than DELAY.
      seen = '0;
      lvl  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         lvl    = ~lvl;
         btn[1] = lvl;
         w      = int'($urandom_range(15, 1));
         repeat (w) begin
            tick(1);
            seen = seen | db | rise | fall;
         end
      end
      btn[1] = 1'b0;
      repeat (LAT + 2) begin
         tick(1);
         seen = seen | db | rise | fall;
      end
      check("glitch_train", seen, '0);

      // One cycle short of DELAY must be rejected.
      seen   = '0;
      btn[1] = 1'b1;
      repeat (DELAY - 1) begin
         tick(1);
         seen = seen | db | rise | fall;
      end
      btn[1] = 1'b0;
      repeat (LAT + 2) begin
         tick(1);
         seen = seen | db | rise | fall;
      end
      check("glitch_15", seen, '0);

      // Exactly DELAY cycles high is accepted, then the return low is accepted too.
      btn = 4'h2;
      tick(DELAY);
      btn = 4'h0;
      tick(1);
      check_all("pulse16_pre", '0, '0, '0, '0);
      tick(1);
      check_all("pulse16_rise", 4'h2, 4'h2, '0, '0);
      tick(DELAY - 1);
      check_all("pulse16_hi", 4'h2, '0, '0, '0);
      tick(1);
      check_all("pulse16_fall", 4'h0, '0, 4'h2, '0);

      // Independence: ch2 rises and ch3 falls on the same edge.
      step_edge("ch3_set", 4'h8, 4'h0, 4'h8, 4'h8, 4'h0);
      tick(2);
      step_edge("ch2_ch3", 4'h4, 4'h8, 4'h4, 4'h4, 4'h8);

      // Reset pulse interrupts a ch0 count; after release ch0 and ch2 both need the full latency.
      btn = 4'h5;
      tick(10);
      check_all("midcount", 4'h4, '0, '0, '0);
      rstn = 1'b0;
      tick(3);
      check_all("midcount_rst", '0, '0, '0, '0);
      rstn = 1'b1;
      tick(LAT - 1);
      check_all("midcount_rel_pre", '0, '0, '0, '0);
      tick(1);
      check_all("midcount_rel_edge", 4'h5, 4'h5, '0, '0);
      step_edge("clear", 4'h0, 4'h5, 4'h0, 4'h0, 4'h5);

      // Long press on ch0: around 100 cycles of debounced high.
      step_edge("long_rise", 4'h1, 4'h0, 4'h1, 4'h1, 4'h0);
      seen = '0;
      repeat (HOLD_CYCLES - 2) begin
         tick(1);
         seen = seen | hold;
      end
      check("hold_early", seen, '0);
      tick(1);
      check("hold_pulse", hold, {3'b000, HOLD_ON});
      seen = '0;
      repeat (60) begin
         tick(1);
         seen = seen | hold;
      end
      check("hold_single", seen, '0);
      step_edge("long_fall", 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);

      // Short press of 30 cycles never reaches the hold threshold.
      seen = '0;
      btn  = 4'h1;
      repeat (30) begin
         tick(1);
         seen = seen | hold;
      end
      btn = 4'h0;
      repeat (2 * LAT) begin
         tick(1);
         seen = seen | hold;
      end
      check("hold_short", seen, '0);
      check_all("final", 4'h0, '0, '0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
